// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared operation decode type for the FIFO pointer controller
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2,
    OP_RW   = 2'd3
  } fifo_op_t;

endpackage

// File: rtl/fifo_wrap_counter.sv
// rtl/fifo_wrap_counter.sv - enabled up-counter that returns to 0 after wrap_val
module fifo_wrap_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] wrap_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    wrap_flag
);

  assign wrap_flag = (count_out == wrap_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (wrap_flag) count_out <= '0;
      else           count_out <= count_out + NUM_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointers, occupancy, flags and sticky errors for any DEPTH >= 2
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [CW-1:0] af_th,
  input  logic [CW-1:0] ae_th,
  output logic          wr_accept,
  output logic          rd_accept,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(DEPTH);

  fifo_op_t      op;
  logic [CW-1:0] count_next;
  logic          unused_wr_wrap;
  logic          unused_rd_wrap;

  // A full FIFO can still take a write when a read frees a slot in the same cycle.
  assign rd_accept = rd_en & ~clear & ~empty;
  assign wr_accept = wr_en & ~clear & (~full | rd_accept);

  always_comb begin
    op         = OP_IDLE;
    count_next = count;
    case ({rd_accept, wr_accept})
      2'b01:   op = OP_WR;
      2'b10:   op = OP_RD;
      2'b11:   op = OP_RW;
      default: op = OP_IDLE;
    endcase
    case (op)
      OP_WR:   count_next = count + CW'(1);
      OP_RD:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  fifo_wrap_counter #(.NUM_CNT_BITS(AW)) u_wr_ptr (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (wr_accept),
    .wrap_val     (LAST_IDX),
    .count_out    (wr_ptr),
    .wrap_flag    (unused_wr_wrap)
  );

  fifo_wrap_counter #(.NUM_CNT_BITS(AW)) u_rd_ptr (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (rd_accept),
    .wrap_val     (LAST_IDX),
    .count_out    (rd_ptr),
    .wrap_flag    (unused_rd_wrap)
  );

  // full/empty come from count_next so they line up with the registered count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      full      <= (count_next == MAX_CNT);
      empty     <= (count_next == '0);
      overflow  <= overflow | (wr_en & ~wr_accept);
      underflow <= underflow | (rd_en & ~rd_accept);
    end
  end

  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - table-driven bench for fifo_ptr_ctrl at DEPTH=5
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 5;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          n_rst;
  logic          clear;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] af_th;
  logic [CW-1:0] ae_th;
  logic          wr_accept;
  logic          rd_accept;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int checks;
  int failures;

  typedef struct {
    logic       clr, wr, rd;
    logic [2:0] af, ae;
    logic       wa, ra;
    logic [2:0] cnt, wp, rp;
    logic       fl, em, ov, un, afl, ael;
  } vec_t;

  vec_t vecs[$];

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .af_th        (af_th),
    .ae_th        (ae_th),
    .wr_accept    (wr_accept),
    .rd_accept    (rd_accept),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addv(input logic clr, wr, rd, input logic [2:0] af, ae,
                      input logic wa, ra, input logic [2:0] cnt, wp, rp,
                      input logic fl, em, ov, un, afl, ael);
    vec_t v;
    v.clr = clr; v.wr = wr; v.rd = rd; v.af = af; v.ae = ae;
    v.wa = wa; v.ra = ra; v.cnt = cnt; v.wp = wp; v.rp = rp;
    v.fl = fl; v.em = em; v.ov = ov; v.un = un; v.afl = afl; v.ael = ael;
    vecs.push_back(v);
  endtask

  task automatic check_state(input string tag, input logic [2:0] cnt, wp, rp,
                             input logic fl, em, ov, un, afl, ael);
    check({tag, " count"},        8'(count),        8'(cnt));
    check({tag, " wr_ptr"},       8'(wr_ptr),       8'(wp));
    check({tag, " rd_ptr"},       8'(rd_ptr),       8'(rp));
    check({tag, " full"},         8'(full),         8'(fl));
    check({tag, " empty"},        8'(empty),        8'(em));
    check({tag, " overflow"},     8'(overflow),     8'(ov));
    check({tag, " underflow"},    8'(underflow),    8'(un));
    check({tag, " almost_full"},  8'(almost_full),  8'(afl));
    check({tag, " almost_empty"}, 8'(almost_empty), 8'(ael));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // clr wr rd af ae | wa ra cnt wp rp full empty ov un afl ael
    addv(0,1,0,4,1, 1,0,1,1,0, 0,0,0,0,0,1);
    addv(0,1,0,4,1, 1,0,2,2,0, 0,0,0,0,0,0);
    addv(0,1,0,4,1, 1,0,3,3,0, 0,0,0,0,0,0);
    addv(0,1,0,4,1, 1,0,4,4,0, 0,0,0,0,1,0);
    addv(0,1,0,4,1, 1,0,5,0,0, 1,0,0,0,1,0);
    addv(0,1,0,4,1, 0,0,5,0,0, 1,0,1,0,1,0);
    addv(0,1,1,4,1, 1,1,5,1,1, 1,0,1,0,1,0);
    addv(0,1,1,4,1, 1,1,5,2,2, 1,0,1,0,1,0);
    addv(0,1,1,4,1, 1,1,5,3,3, 1,0,1,0,1,0);
    addv(0,0,1,4,1, 0,1,4,3,4, 0,0,1,0,1,0);
    addv(0,0,1,4,1, 0,1,3,3,0, 0,0,1,0,0,0);
    addv(1,1,0,4,1, 0,0,0,0,0, 0,1,0,0,0,1);
    addv(0,1,1,4,1, 1,0,1,1,0, 0,0,0,1,0,1);
    addv(0,0,1,4,1, 0,1,0,1,1, 0,1,0,1,0,1);
    addv(0,0,1,4,1, 0,0,0,1,1, 0,1,0,1,0,1);
    addv(0,0,0,0,5, 0,0,0,1,1, 0,1,0,1,1,1);
    addv(1,0,0,4,1, 0,0,0,0,0, 0,1,0,0,0,1);
    addv(0,1,0,4,1, 1,0,1,1,0, 0,0,0,0,0,1);
    addv(0,1,0,4,1, 1,0,2,2,0, 0,0,0,0,0,0);
    addv(0,1,0,4,1, 1,0,3,3,0, 0,0,0,0,0,0);
    addv(0,1,0,4,1, 1,0,4,4,0, 0,0,0,0,1,0);

    n_rst = 1'b0;
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    af_th = 3'd4;
    ae_th = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 3'd0, 3'd0, 3'd0, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clear = vecs[i].clr;
      wr_en = vecs[i].wr;
      rd_en = vecs[i].rd;
      af_th = vecs[i].af;
      ae_th = vecs[i].ae;
      #1;
      check($sformatf("v%0d wr_accept", i), 8'(wr_accept), 8'(vecs[i].wa));
      check($sformatf("v%0d rd_accept", i), 8'(rd_accept), 8'(vecs[i].ra));
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].wp, vecs[i].rp,
                  vecs[i].fl, vecs[i].em, vecs[i].ov, vecs[i].un,
                  vecs[i].afl, vecs[i].ael);
    end

    // Threshold change acts combinationally at count 4, no edge needed.
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
    af_th = 3'd5;
    #1;
    check("af_th change almost_full", 8'(almost_full), 8'd0);
    af_th = 3'd4;
    #1;
    check("af_th restore almost_full", 8'(almost_full), 8'd1);

    // Asynchronous reset between edges with count 4 and a write pending.
    @(posedge clk);
    #2;
    wr_en = 1'b1;
    n_rst = 1'b0;
    #1;
    check_state("async_reset", 3'd0, 3'd0, 3'd0, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    wr_en = 1'b0;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset count", 8'(count), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised FIFO pointer and occupancy controller for the packet buffers. It generates write and read pointers that wrap at an arbitrary `DEPTH`, so power-of-two depth is not required. It also produces an occupancy count, full/empty flags, programmable almost-full/almost-empty flags and sticky overflow/underflow errors. It sits between the producer/consumer handshakes and the dual-port buffer RAM, and drives its address and write/read strobes.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries. Legal range is 2 or more; non-power-of-two is allowed.
- `AW`, default `$clog2(DEPTH)`: pointer width. Derived; never overridden.
- `CW`, default `$clog2(DEPTH+1)`: count and threshold width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush; highest priority after reset.
- `wr_en`  in  1  producer write request.
- `rd_en`  in  1  consumer read request.
- `af_th`  in  CW  almost-full threshold.
- `ae_th`  in  CW  almost-empty threshold.
- `wr_accept`  out  1  write performed this cycle; RAM write strobe.
- `rd_accept`  out  1  read performed this cycle; RAM read strobe.
- `wr_ptr`  out  AW  RAM write address.
- `rd_ptr`  out  AW  RAM read address.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `full`, `empty`  out  1  `count==DEPTH` / `count==0`.
- `almost_full`  out  1  `count >= af_th`.
- `almost_empty`  out  1  `count <= ae_th`.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- **Reset values:** `wr_ptr`=0, `rd_ptr`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0. `almost_*` follow their compare rules against `count`=0.
- **Write acceptance:** `wr_accept = wr_en & ~clear & (~full | rd_accept)`. A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- **Read acceptance:** `rd_accept = rd_en & ~clear & ~empty`. There is no write-to-read bypass: a read on an empty FIFO is rejected even if a write is accepted that cycle.
- **Operation decode:** {`OP_IDLE`, `OP_WR`, `OP_RD`, `OP_RW`} from the two accept signals.
  - `OP_WR`: count +1, `wr_ptr` advances.
  - `OP_RD`: count −1, `rd_ptr` advances.
  - `OP_RW`: count unchanged, both pointers advance.
  - `OP_IDLE`: no change.
- **Pointer wrap:** a pointer at `DEPTH-1` advances to 0. Pointers never take values of `DEPTH` or above.
- **Count arithmetic:** performed at CW bits. Count cannot leave 0..DEPTH by construction; no saturation logic is needed.
- **overflow:** set when `wr_en & ~wr_accept & ~clear`.
- **underflow:** set when `rd_en & ~rd_accept & ~clear`.
- **Sticky error clearing:** both error flags stay set until `clear` or reset. Setting an error does not alter pointers or count.
- **clear:** on the next edge, pointers, count and both sticky errors go to 0. `wr_en`/`rd_en` are ignored that cycle and both accepts are 0.
- **Threshold corner cases:** `af_th`=0 makes `almost_full` always 1. `ae_th` ≥ DEPTH makes `almost_empty` always 1. No other special-casing.

## Timing
- Accepts are combinational from current registered state plus `wr_en`/`rd_en`/`clear`, within the same cycle.
- `wr_ptr`, `rd_ptr`, `count`, `full`, `empty`, `overflow` and `underflow` are registered and update one edge after the accepted request (1-cycle latency).
- `full`/`empty` are registered, computed from next-count, and align exactly with `count`.
- `almost_full`/`almost_empty` are combinational compares of registered `count` against the threshold ports. Threshold changes take effect in the same cycle.
- Reset mid-operation: all registered outputs go to their reset values asynchronously; an in-flight request is lost.
- Protocol: a requester holds `wr_en`/`rd_en` until it sees the matching accept. Accepted items are exactly those with the accept high at the edge.

## Structure
- Shared package `fifo_pkg`: `typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD, OP_RW} fifo_op_t`. Width-dependent types stay local because they depend on `DEPTH`.
- Sub-module `fifo_wrap_counter #(NUM_CNT_BITS)` provides:
  - ports `clk`, `n_rst`, `clear`, `count_enable`, `wrap_val`, `count_out`, `wrap_flag`;
  - behaviour: it wraps to 0 after `wrap_val`.
- `fifo_wrap_counter` is instantiated twice, once per pointer, with `wrap_val = DEPTH-1`. Count, flags and decode live in the top.

## Test plan
1. **Non-power-of-two fill:** `DEPTH`=5; 5 writes from empty → count 1,2,3,4,5; `full`=1 after the 5th edge; `wr_ptr` 1,2,3,4,0. Then a 6th write → `wr_accept`=0, `overflow`=1, count stays 5.
2. **Read/write at full:** while full, `wr_en`=`rd_en`=1 for 3 cycles → both accepts 1, count stays 5, both pointers advance by 3 with wrap.
3. **Read on empty with write:** empty, `wr_en`=`rd_en`=1 → `rd_accept`=0, `underflow`=1, count=1, `rd_ptr` unchanged.
4. **Thresholds:** `af_th`=4, `ae_th`=1; write 4 → `almost_empty` drops at count 2, `almost_full` rises at count 4. Change `af_th` to 5 → `almost_full` drops the same cycle.
5. **Clear during traffic:** `clear` with `wr_en`=1 at count 3 and `overflow`=1 → accepts 0, next edge count=0, pointers 0, `overflow`=0, `empty`=1.
6. **Reset mid-operation:** assert `n_rst` low between edges at count 4 → all outputs at reset values immediately, before the next edge.
